// File: rtl/tmr_scrub_ctrl_if.sv
// Host access port of the TMR scrub controller: request/grant handshake
// plus voted read-data return.
interface tmr_scrub_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
);
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic [DATA_W-1:0] host_rdata;
   logic              host_rvalid;

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rdata, host_rvalid
   );

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rdata, host_rvalid
   );
endinterface

// File: rtl/tmr_scrub_ctrl.sv
// Sequencer for triplicated storage with an external majority voter.
// Arbitrates the host port against a background scrubber, routes every
// read through the voter and writes the voted word back to disagreeing
// replicas. Optional macro TMR_SCRUB_EN enables the background scrubber;
// without it, correction happens only on host reads.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accept host access (host first) or issue a scrub read
// RD    | replica data valid; present to voter, register vote/mis/uc
// VOTE  | return host data; flag uncorrectable or schedule writeback
// WB    | write voted word to disagreeing replicas, count the fault
module tmr_scrub_ctrl #(
   parameter int DATA_W       = 4,
   parameter int ADDR_W       = 4,
   parameter int SCRUB_PERIOD = 64,
   parameter int CNT_W        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   tmr_scrub_ctrl_if.slave     host,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [2:0]          mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata_1,
   input  logic [DATA_W-1:0]   mem_rdata_2,
   input  logic [DATA_W-1:0]   mem_rdata_3,
   output logic [DATA_W-1:0]   data_1,
   output logic [DATA_W-1:0]   data_2,
   output logic [DATA_W-1:0]   data_3,
   input  logic [DATA_W-1:0]   voted_q,
   output logic                scrub_busy,
   output logic                fault_pulse,
   output logic                uncorr,
   output logic [ADDR_W-1:0]   fault_addr,
   output logic [CNT_W-1:0]    fault_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   if (SCRUB_PERIOD < 2) begin : g_bad_period
      $error("SCRUB_PERIOD must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, RD, VOTE, WB} state_t;

   state_t            state;
   logic              op_host;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] vote_q;
   logic [2:0]        mis_q;
   logic              uc_q;
   logic              uncorr_q;
   logic [ADDR_W-1:0] fault_addr_q;
   logic [CNT_W-1:0]  fault_cnt_q;

   logic              host_go;
   logic              scrub_go;
   logic              scrub_busy_q;
   logic [ADDR_W-1:0] scrub_addr;
   logic [2:0]        mis_c;
   logic              uc_c;

   // Host wins arbitration; gated by rst_n so nothing strobes during reset.
   assign host_go  = rst_n && (state == IDLE) && host.host_req;
   assign scrub_go = rst_n && (state == IDLE) && !host.host_req && scrub_busy_q;

   assign mis_c[0] = (mem_rdata_1 != voted_q);
   assign mis_c[1] = (mem_rdata_2 != voted_q);
   assign mis_c[2] = (mem_rdata_3 != voted_q);
   assign uc_c     = (mem_rdata_1 != mem_rdata_2) && (mem_rdata_1 != mem_rdata_3) &&
                     (mem_rdata_2 != mem_rdata_3);

   assign data_1 = (state == RD) ? mem_rdata_1 : '0;
   assign data_2 = (state == RD) ? mem_rdata_2 : '0;
   assign data_3 = (state == RD) ? mem_rdata_3 : '0;

   assign host.host_gnt    = host_go;
   assign host.host_rvalid = (state == VOTE) && op_host;
   assign host.host_rdata  = ((state == VOTE) && op_host) ? vote_q : '0;

   assign fault_pulse = (state == WB);
   assign uncorr      = uncorr_q;
   assign fault_addr  = fault_addr_q;
   assign fault_cnt   = fault_cnt_q;
   assign scrub_busy  = scrub_busy_q;

   // Replica bank strobes: host access or scrub read from IDLE, writeback from WB.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = 3'b000;
      if (host_go) begin
         mem_en   = 1'b1;
         mem_we   = host.host_we;
         mem_addr = host.host_addr;
         if (host.host_we) begin
            mem_wdata = host.host_wdata;
            mem_wmask = 3'b111;
         end
      end else if (scrub_go) begin
         mem_en   = 1'b1;
         mem_addr = scrub_addr;
      end else if (state == WB) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = op_addr;
         mem_wdata = vote_q;
         mem_wmask = mis_q;
      end
   end

   // Main sequencer: read, vote, optional writeback, fault bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         op_host      <= 1'b0;
         op_addr      <= '0;
         vote_q       <= '0;
         mis_q        <= 3'b000;
         uc_q         <= 1'b0;
         uncorr_q     <= 1'b0;
         fault_addr_q <= '0;
         fault_cnt_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (host_go && !host.host_we) begin
                  state   <= RD;
                  op_host <= 1'b1;
                  op_addr <= host.host_addr;
               end else if (scrub_go) begin
                  state   <= RD;
                  op_host <= 1'b0;
                  op_addr <= scrub_addr;
               end
            end
            RD: begin
               vote_q <= voted_q;
               mis_q  <= mis_c;
               uc_q   <= uc_c;
               state  <= VOTE;
            end
            VOTE: begin
               if (uc_q) begin
                  uncorr_q     <= 1'b1;
                  fault_addr_q <= op_addr;
                  state        <= IDLE;
               end else if (mis_q != 3'b000) begin
                  state <= WB;
               end else begin
                  state <= IDLE;
               end
            end
            WB: begin
               if (fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + 1'b1;
               fault_addr_q <= op_addr;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TMR_SCRUB_EN
   localparam int TMR_W = $clog2(SCRUB_PERIOD);

   logic [TMR_W-1:0] scrub_tmr;
   logic             scrub_done;

   // A scrub operation ends when VOTE returns to IDLE or after its writeback.
   assign scrub_done = !op_host &&
                       (((state == VOTE) && (uc_q || (mis_q == 3'b000))) || (state == WB));

   // Idle timer launches a pass; the pass walks every address once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scrub_tmr    <= '0;
         scrub_addr   <= '0;
         scrub_busy_q <= 1'b0;
      end else begin
         if ((state == IDLE) && !scrub_busy_q) begin
            if (scrub_tmr == TMR_W'(SCRUB_PERIOD - 1)) begin
               scrub_busy_q <= 1'b1;
               scrub_addr   <= '0;
               scrub_tmr    <= '0;
            end else begin
               scrub_tmr <= scrub_tmr + 1'b1;
            end
         end
         if (scrub_done) begin
            scrub_addr <= scrub_addr + 1'b1;
            if (scrub_addr == ADDR_W'(DEPTH - 1)) begin
               scrub_busy_q <= 1'b0;
               scrub_tmr    <= '0;
            end
         end
      end
   end
`else
   assign scrub_addr   = '0;
   assign scrub_busy_q = 1'b0;
`endif

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: replica banks and a bitwise majority voter
// are modelled here, a transaction-level reference predicts every output
// each cycle, and directed scenarios pin key values with literals.
module tb_tmr_scrub_ctrl;
   localparam int DATA_W = 4, ADDR_W = 4, DEPTH = 16, SCRUB_PERIOD = 64, CNT_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tmr_scrub_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hif ();

   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_wmask;
   logic [DATA_W-1:0] mem_rdata_1 = '0, mem_rdata_2 = '0, mem_rdata_3 = '0;
   logic [DATA_W-1:0] data_1, data_2, data_3, voted_q;
   logic              scrub_busy, fault_pulse, uncorr;
   logic [ADDR_W-1:0] fault_addr;
   logic [CNT_W-1:0]  fault_cnt;

   tmr_scrub_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCRUB_PERIOD(SCRUB_PERIOD), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .host(hif.slave),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata_1(mem_rdata_1), .mem_rdata_2(mem_rdata_2),
      .mem_rdata_3(mem_rdata_3), .data_1(data_1), .data_2(data_2), .data_3(data_3),
      .voted_q(voted_q), .scrub_busy(scrub_busy), .fault_pulse(fault_pulse),
      .uncorr(uncorr), .fault_addr(fault_addr), .fault_cnt(fault_cnt)
   );

   function automatic logic [DATA_W-1:0] maj(input logic [DATA_W-1:0] a, b, c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign voted_q = maj(data_1, data_2, data_3);

   // Replica banks with a preload side door driven by the stimulus.
   logic [DATA_W-1:0] rep1 [DEPTH];
   logic [DATA_W-1:0] rep2 [DEPTH];
   logic [DATA_W-1:0] rep3 [DEPTH];
   logic              pl_en = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   logic [DATA_W-1:0] pl_v1 = '0, pl_v2 = '0, pl_v3 = '0;

   always @(posedge clk) begin
      if (mem_en && !mem_we) begin
         mem_rdata_1 <= rep1[mem_addr];
         mem_rdata_2 <= rep2[mem_addr];
         mem_rdata_3 <= rep3[mem_addr];
      end
      if (mem_en && mem_we) begin
         if (mem_wmask[0]) rep1[mem_addr] <= mem_wdata;
         if (mem_wmask[1]) rep2[mem_addr] <= mem_wdata;
         if (mem_wmask[2]) rep3[mem_addr] <= mem_wdata;
      end
      if (pl_en) begin
         rep1[pl_addr] <= pl_v1;
         rep2[pl_addr] <= pl_v2;
         rep3[pl_addr] <= pl_v3;
      end
   end

   int n_vec = 0, n_err = 0, cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: at most one read operation in flight, tracked by the
   // cycle it was issued; the scrubber as an idle-cycle count and address.
   bit                op_act, op_host, op_wb, op_uc;
   int                op_iss;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_vote, op_r1, op_r2, op_r3;
   logic [2:0]        op_mis;
   bit                m_busy, m_unc;
   int                m_tmr, m_cnt;
   logic [ADDR_W-1:0] m_saddr, m_faddr;
   int                n_pulse = 0, n_mem_en = 0;
   logic [ADDR_W-1:0] last_wb_addr = '0;
   logic [DATA_W-1:0] last_wb_data = '0;
   logic [2:0]        last_wb_mask = '0;

   task automatic op_end();
      op_act = 0;
      if (!op_host) begin
         if (m_saddr == ADDR_W'(DEPTH - 1)) m_busy = 0;
         m_saddr = m_saddr + 1'b1;
      end
   endtask

   always @(negedge clk) begin
      int ph;
      bit idle, gnt_e, srd_e, wb_e, rv_e;
      cyc++;
      if (!rst_n) begin
         chk("reset_outputs",
             {hif.host_gnt, hif.host_rvalid, hif.host_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
              scrub_busy, fault_pulse, uncorr, fault_addr, fault_cnt}, '0);
         chk("reset_data", {data_1, data_2, data_3}, '0);
         op_act = 0; m_busy = 0; m_unc = 0; m_tmr = 0; m_cnt = 0; m_saddr = '0; m_faddr = '0;
      end else begin
         ph    = op_act ? cyc - op_iss : -1;
         idle  = !op_act;
         gnt_e = idle && hif.host_req;
         srd_e = idle && !hif.host_req && m_busy;
         wb_e  = op_act && op_wb && (ph == 3);
         rv_e  = op_act && op_host && (ph == 2);
         chk("host_gnt", hif.host_gnt, gnt_e);
         chk("mem_en", mem_en, gnt_e || srd_e || wb_e);
         if (gnt_e) begin
            chk("host_mem_we", mem_we, hif.host_we);
            chk("host_mem_addr", mem_addr, hif.host_addr);
            if (hif.host_we) chk("host_wr", {mem_wdata, mem_wmask}, {hif.host_wdata, 3'b111});
         end else if (srd_e) begin
            chk("scrub_rd", {mem_we, mem_addr}, {1'b0, m_saddr});
         end else if (wb_e) begin
            chk("wb", {mem_we, mem_addr, mem_wdata, mem_wmask}, {1'b1, op_addr, op_vote, op_mis});
         end
         chk("host_rvalid", hif.host_rvalid, rv_e);
         if (rv_e) chk("host_rdata", hif.host_rdata, op_vote);
         chk("fault_pulse", fault_pulse, wb_e);
         if (op_act && ph == 1) chk("voter_in", {data_1, data_2, data_3}, {op_r1, op_r2, op_r3});
         chk("scrub_busy", scrub_busy, m_busy);
         chk("uncorr", uncorr, m_unc);
         chk("fault_addr", fault_addr, m_faddr);
         chk("fault_cnt", fault_cnt, m_cnt);

         if (fault_pulse) n_pulse++;
         if (mem_en) n_mem_en++;
         if (mem_en && mem_we && mem_wmask != 3'b111) begin
            last_wb_addr = mem_addr; last_wb_data = mem_wdata; last_wb_mask = mem_wmask;
         end

`ifdef TMR_SCRUB_EN
         if (idle && !m_busy) begin
            if (m_tmr == SCRUB_PERIOD - 1) begin
               m_busy = 1; m_tmr = 0; m_saddr = '0;
            end else begin
               m_tmr++;
            end
         end
`endif
         if ((gnt_e && !hif.host_we) || srd_e) begin
            op_addr = gnt_e ? hif.host_addr : m_saddr;
            op_r1 = rep1[op_addr]; op_r2 = rep2[op_addr]; op_r3 = rep3[op_addr];
            op_vote = maj(op_r1, op_r2, op_r3);
            op_mis  = {op_r3 != op_vote, op_r2 != op_vote, op_r1 != op_vote};
            op_uc   = (op_r1 != op_r2) && (op_r1 != op_r3) && (op_r2 != op_r3);
            op_wb   = !op_uc && (op_mis != 3'b000);
            op_iss  = cyc; op_host = gnt_e; op_act = 1;
         end else if (op_act && ph == 2) begin
            if (op_uc) begin m_unc = 1; m_faddr = op_addr; end
            if (!op_wb) op_end();
         end else if (op_act && ph == 3) begin
            if (m_cnt < 255) m_cnt++;
            m_faddr = op_addr;
            op_end();
         end
      end
   end

   // Stimulus tasks are entered and left just after a rising edge.
   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v1, v2, v3);
      pl_addr = a; pl_v1 = v1; pl_v2 = v2; pl_v3 = v3; pl_en = 1'b1;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic wait_gnt(input string nm, output int waited);
      waited = 0;
      forever begin
         @(negedge clk);
         if (hif.host_gnt) break;
         waited++;
         if (waited > 300) begin chk({nm, "_gnt_timeout"}, 1, 0); break; end
      end
      @(posedge clk); #1;
      hif.host_req = 1'b0;
   endtask

   task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int w;
      hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = a; hif.host_wdata = d;
      wait_gnt("wr", w);
   endtask

   task automatic host_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] rd,
                            output int lat, output int waited);
      hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = a; hif.host_wdata = '0;
      wait_gnt("rd", waited);
      lat = 1; rd = '0;
      forever begin
         @(negedge clk);
         if (hif.host_rvalid) begin rd = hif.host_rdata; break; end
         lat++;
         if (lat > 10) begin chk("rvalid_timeout", 1, 0); break; end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] rd;
      int lat, w, p0, k;
      bit found;
      hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
      @(posedge clk); #1;
      for (int a = 0; a < DEPTH; a++) preload(ADDR_W'(a), '0, '0, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: clean write then read
      host_write(4'd3, 4'hA);
      chk("t1_reps", {rep1[3], rep2[3], rep3[3]}, 12'hAAA);
      host_read(4'd3, rd, lat, w);
      chk("t1_rdata", rd, 4'hA);
      chk("t1_latency", lat, 2);
      repeat (2) @(posedge clk); #1;
      chk("t1_fault_cnt", fault_cnt, 0);

      // 2: single-replica fault corrected by a host read
      preload(4'd5, 4'hD, 4'hD, 4'h8);
      p0 = n_pulse;
      host_read(4'd5, rd, lat, w);
      chk("t2_rdata", rd, 4'hD);
      repeat (3) @(posedge clk); #1;
      chk("t2_wb", {last_wb_addr, last_wb_mask, last_wb_data}, {4'd5, 3'b100, 4'hD});
      chk("t2_pulses", n_pulse - p0, 1);
      chk("t2_fault_cnt", fault_cnt, 1);
      chk("t2_fault_addr", fault_addr, 5);
      chk("t2_reps", {rep1[5], rep2[5], rep3[5]}, 12'hDDD);

      // 3: no two replicas agree
      preload(4'd7, 4'h1, 4'h2, 4'h4);
      p0 = n_pulse;
      host_read(4'd7, rd, lat, w);
      repeat (3) @(posedge clk); #1;
      chk("t3_uncorr", uncorr, 1);
      chk("t3_fault_addr", fault_addr, 7);
      chk("t3_fault_cnt", fault_cnt, 1);
      chk("t3_no_pulse", n_pulse - p0, 0);
      chk("t3_reps", {rep1[7], rep2[7], rep3[7]}, 12'h124);

      // 6: reset asserted during writeback
      preload(4'd11, 4'h9, 4'h9, 4'h0);
      hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 4'd11;
      wait_gnt("t6", w);
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(negedge clk);
         if (fault_pulse) found = 1;
      end
      chk("t6_reached_wb", found, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_outputs_zero", {mem_en, mem_we, fault_pulse, uncorr, fault_cnt, hif.host_rvalid}, '0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      k = n_mem_en;
      repeat (6) @(posedge clk); #1;
      chk("t6_no_strobe", n_mem_en - k, 0);
      chk("t6_reps_unfixed", {rep1[11], rep2[11], rep3[11]}, 12'h990);
      host_read(4'd11, rd, lat, w);
      chk("t6_rdata", rd, 4'h9);
      repeat (3) @(posedge clk); #1;
      chk("t6_fault_cnt", fault_cnt, 1);

`ifdef TMR_SCRUB_EN
      // 4: scrubber finds and fixes replica 2 at address 9
      preload(4'd9, 4'hB, 4'h6, 4'hB);
      preload(4'd12, 4'hC, 4'hC, 4'h3);
      found = 0;
      for (int i = 0; i < SCRUB_PERIOD + 4 * DEPTH + 20 && !found; i++) begin
         @(negedge clk);
         if (mem_en && mem_we && mem_addr == 4'd9) found = 1;
      end
      chk("t4_wb_seen", found, 1);
      chk("t4_wb", {mem_wmask, mem_wdata}, {3'b010, 4'hB});

      // 5: host request raised while the scrub read of 12 is in VOTE
      found = 0;
      for (int i = 0; i < 4 * DEPTH && !found; i++) begin
         @(negedge clk);
         if (mem_en && !mem_we && !hif.host_gnt && mem_addr == 4'd12) found = 1;
      end
      chk("t5_scrub_rd_seen", found, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      host_read(4'd12, rd, lat, w);
      chk("t5_gnt_wait", w, 2);
      chk("t5_scrub_wb", {last_wb_addr, last_wb_mask, last_wb_data}, {4'd12, 3'b100, 4'hC});
      chk("t5_rdata", rd, 4'hC);
      found = 0;
      for (int i = 0; i < 4 * DEPTH && !found; i++) begin
         @(negedge clk);
         if (!scrub_busy) found = 1;
      end
      chk("t4_busy_falls", found, 1);
      chk("t4_reps", {rep1[9], rep2[9], rep3[9]}, 12'hBBB);
`else
      // Without the scrubber a latent fault stays put
      preload(4'd9, 4'hB, 4'h6, 4'hB);
      k = n_mem_en;
      repeat (SCRUB_PERIOD + 3 * DEPTH) @(posedge clk); #1;
      chk("noscrub_no_strobe", n_mem_en - k, 0);
      chk("noscrub_reps", {rep1[9], rep2[9], rep3[9]}, 12'hB6B);
      host_read(4'd9, rd, lat, w);
      chk("noscrub_rdata", rd, 4'hB);
`endif
      repeat (4) @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/tmr_scrub_ctrl.md
Name: tmr_scrub_ctrl

Overview:
- Sequencer for the triplicated 4-bit storage plus its external majority voter (inputs data_1/2/3, output voted_q).
- Arbitrates one host port against a background scrubber for access to the three replica banks.
- Routes every read through the voter and writes the voted word back to each disagreeing replica.
- Reports correctable and uncorrectable faults.

Parameters:
- DATA_W, 4, replica/voter word width.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W.
- SCRUB_PERIOD, 64, idle cycles between scrub passes (>=2).
- CNT_W, 8, fault counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- host_req  in  1  host access request, held until host_gnt.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle grant; request consumed.
- host_rdata  out  DATA_W  voted read data.
- host_rvalid  out  1  one-cycle read-data strobe.
- mem_en  out  1  replica bank access enable.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  bank address (common to all replicas).
- mem_wdata  out  DATA_W  write data (common to all replicas).
- mem_wmask  out  3  per-replica write select, bit i = replica i+1.
- mem_rdata_1/2/3  in  DATA_W each  replica read data; valid 1 cycle after mem_en & !mem_we.
- data_1/2/3  out  DATA_W each  voter inputs.
- voted_q  in  DATA_W  voter output, combinational, same cycle.
- scrub_busy  out  1  scrub pass in progress.
- fault_pulse  out  1  one cycle per correctable fault.
- uncorr  out  1  sticky; no two replicas agreed.
- fault_addr  out  ADDR_W  address of the last fault.
- fault_cnt  out  CNT_W  saturating count of correctable faults.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; scrub timer, scrub_addr, fault_cnt, fault_addr and uncorr are cleared.
  - All outputs are 0.
  - Reset mid-operation drops any pending read or writeback; no mem strobe follows deassertion.
- States: IDLE, RD, VOTE, WB.
- IDLE, host write (host_req & host_we):
  - Same cycle: host_gnt=1, mem_en=1, mem_we=1, mem_wmask=3'b111, address and data from the host port.
  - Stays in IDLE.
- IDLE, host read:
  - Same cycle: host_gnt=1, mem_en=1, mem_we=0; state moves to RD.
  - Host requests always win over scrub.
- RD (rdata cycle):
  - data_i = mem_rdata_i.
  - mis[i] = (mem_rdata_i != voted_q).
  - uc = no pair of replicas equal.
  - Registers vote, mis and uc; next state VOTE.
- VOTE:
  - For a host read: host_rdata = registered vote, host_rvalid=1. Host read latency is grant+2 cycles.
  - If uc: uncorr is set, fault_addr is captured, no writeback; next state IDLE.
  - Else if mis != 0: next state WB.
  - Else: next state IDLE.
- WB (one cycle):
  - mem_en=1, mem_we=1, mem_wdata = vote, mem_wmask = mis.
  - fault_pulse=1, fault_cnt += 1 (saturating at all-ones), fault_addr captured.
  - Next state IDLE.
- Atomicity: host_gnt=0 in RD/VOTE/WB, so no host write can intervene between a read and its writeback.
- Scrub timer:
  - Increments in IDLE while no pass is active.
  - At SCRUB_PERIOD-1: scrub_busy=1, scrub_addr=0, timer cleared.
- Scrub access:
  - While scrub_busy, in IDLE with host_req=0: issue a read at scrub_addr and enter RD.
  - The scrub sequence is identical to a host read except host_rvalid stays 0.
  - scrub_addr increments on leaving VOTE/WB.
  - After address DEPTH-1: scrub_busy=0 and the timer restarts.
- uncorr clears only on reset.

Optional Feature:
- Macro: TMR_SCRUB_EN.
- Defined: background scrubber as described.
- Undefined:
  - Timer and scrub_addr logic are removed; scrub_busy is tied to 0.
  - Correction happens only on host reads.

Test Plan:
1. Host write 4'hA @3, then read @3 with all replicas 4'hA -> host_gnt pulses, host_rvalid 2 cycles after grant with host_rdata=4'hA; no WB, fault_cnt=0.
2. Replicas @5 = 4'hD/4'hD/4'h8, host read -> host_rdata=4'hD; WB with mem_wmask=3'b100, mem_wdata=4'hD; fault_pulse once, fault_cnt=1, fault_addr=5.
3. Replicas @7 = 4'h1/4'h2/4'h4 -> uncorr=1, fault_addr=7, no mem write, fault_cnt unchanged.
4. TMR_SCRUB_EN, replica 2 @9 = 4'h6, others 4'hB, no host traffic -> within SCRUB_PERIOD+3*DEPTH+DEPTH cycles, WB @9 with mem_wmask=3'b010 and data 4'hB; scrub_busy then falls.
5. host_req asserted while a scrub read is in VOTE -> host_gnt only after IDLE is re-entered; the scrub writeback completes first; host read returns the corrected value.
6. rst_n dropped during WB -> outputs 0 immediately, fault_cnt=0, no mem_en after release until a new request.
